// File: rtl/ifft_twiddle_mult_stage_if.sv
// Streaming bus between the 4th-stage butterfly, the twiddle ROM and the next stage.
// The slave modport is the multiplier stage's view of the bus.
interface ifft_twiddle_mult_stage_if #(
    parameter int unsigned DATA_WIDTH = 15,
    parameter int unsigned TW_WIDTH   = 15
);
    logic                         in_valid;
    logic                         in_sof;
    logic signed [DATA_WIDTH-1:0] in_real;
    logic signed [DATA_WIDTH-1:0] in_imag;
    logic        [5:0]            tw_addr;
    logic signed [TW_WIDTH-1:0]   tw_real;
    logic signed [TW_WIDTH-1:0]   tw_imag;
    logic                         out_valid;
    logic                         out_sof;
    logic signed [DATA_WIDTH-1:0] out_real;
    logic signed [DATA_WIDTH-1:0] out_imag;
    logic                         frame_done;
    logic                         ovf_flag;

    modport slave (
        input  in_valid, in_sof, in_real, in_imag, tw_real, tw_imag,
        output tw_addr, out_valid, out_sof, out_real, out_imag, frame_done, ovf_flag
    );

    modport master (
        output in_valid, in_sof, in_real, in_imag, tw_real, tw_imag,
        input  tw_addr, out_valid, out_sof, out_real, out_imag, frame_done, ovf_flag
    );
endinterface

// File: rtl/ifft_twiddle_mult_stage.sv
// Twiddle multiplier after the 4th SDF butterfly: indexes the twiddle ROM, multiplies,
// rounds half-up and saturates, with a fixed 3-cycle latency.
module ifft_twiddle_mult_stage #(
    parameter int unsigned NFFT       = 64,
    parameter int unsigned DATA_WIDTH = 15,
    parameter int unsigned TW_WIDTH   = 15,
    parameter int unsigned TW_FRAC    = 10
) (
    input logic                      clk,
    input logic                      rst,
    ifft_twiddle_mult_stage_if.slave bus_io
);
    localparam int unsigned PW = DATA_WIDTH + TW_WIDTH;
    localparam int unsigned SW = PW + 1;
    localparam logic [5:0]           LastIdx = 6'(NFFT - 1);
    localparam logic signed [SW-1:0] RndK    = SW'(2 ** (TW_FRAC - 1));
    localparam logic signed [SW-1:0] MaxVal  = SW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] MinVal  = ~MaxVal;

    // Returns {saturated, value}.
    function automatic logic [DATA_WIDTH:0] rnd_sat(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] r;
        r = (x + RndK) >>> TW_FRAC;
        if (r > MaxVal) begin
            rnd_sat = {1'b1, MaxVal[DATA_WIDTH-1:0]};
        end else if (r < MinVal) begin
            rnd_sat = {1'b1, MinVal[DATA_WIDTH-1:0]};
        end else begin
            rnd_sat = {1'b0, r[DATA_WIDTH-1:0]};
        end
    endfunction

    logic [5:0] idx_q, idx_d, idx_cur;

    logic signed [DATA_WIDTH-1:0] s1_ar_q, s1_ai_q;
    logic signed [TW_WIDTH-1:0]   s1_wr_q, s1_wi_q;
    logic                         s1_vld_q, s1_sof_q, s1_last_q;

    logic signed [PW-1:0] s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;
    logic signed [PW-1:0] s2_rr_d, s2_ii_d, s2_ri_d, s2_ir_d;
    logic                 s2_vld_q, s2_sof_q, s2_last_q;

    logic signed [SW-1:0]   pr, pi;
    logic [DATA_WIDTH:0]    re_rs, im_rs;

    logic                         out_vld_q, out_sof_q, done_q, ovf_q;
    logic signed [DATA_WIDTH-1:0] out_re_q, out_im_q;

    // A start-of-frame sample always takes address 0, whatever the counter holds.
    always_comb begin
        idx_cur = (bus_io.in_valid && bus_io.in_sof) ? 6'd0 : idx_q;
        idx_d   = idx_q;
        if (bus_io.in_valid) begin
            idx_d = (idx_cur == LastIdx) ? 6'd0 : idx_cur + 6'd1;
        end
    end

    assign bus_io.tw_addr = idx_cur;

    always_comb begin
        s2_rr_d = PW'(s1_ar_q) * PW'(s1_wr_q);
        s2_ii_d = PW'(s1_ai_q) * PW'(s1_wi_q);
        s2_ri_d = PW'(s1_ar_q) * PW'(s1_wi_q);
        s2_ir_d = PW'(s1_ai_q) * PW'(s1_wr_q);
    end

    always_comb begin
        pr    = {s2_rr_q[PW-1], s2_rr_q} - {s2_ii_q[PW-1], s2_ii_q};
        pi    = {s2_ri_q[PW-1], s2_ri_q} + {s2_ir_q[PW-1], s2_ir_q};
        re_rs = rnd_sat(pr);
        im_rs = rnd_sat(pi);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            s1_ar_q   <= '0;
            s1_ai_q   <= '0;
            s1_wr_q   <= '0;
            s1_wi_q   <= '0;
            s1_vld_q  <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s2_rr_q   <= '0;
            s2_ii_q   <= '0;
            s2_ri_q   <= '0;
            s2_ir_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_sof_q  <= 1'b0;
            s2_last_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_sof_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_re_q  <= '0;
            out_im_q  <= '0;
        end else begin
            idx_q     <= idx_d;
            s1_vld_q  <= bus_io.in_valid;
            s1_sof_q  <= bus_io.in_valid & bus_io.in_sof;
            s1_last_q <= bus_io.in_valid & (idx_cur == LastIdx);
            if (bus_io.in_valid) begin
                s1_ar_q <= bus_io.in_real;
                s1_ai_q <= bus_io.in_imag;
                s1_wr_q <= bus_io.tw_real;
                s1_wi_q <= bus_io.tw_imag;
            end
            s2_vld_q  <= s1_vld_q;
            s2_sof_q  <= s1_sof_q;
            s2_last_q <= s1_last_q;
            if (s1_vld_q) begin
                s2_rr_q <= s2_rr_d;
                s2_ii_q <= s2_ii_d;
                s2_ri_q <= s2_ri_d;
                s2_ir_q <= s2_ir_d;
            end
            out_vld_q <= s2_vld_q;
            out_sof_q <= s2_vld_q & s2_sof_q;
            done_q    <= s2_vld_q & s2_last_q;
            ovf_q     <= ovf_q | (s2_vld_q & (re_rs[DATA_WIDTH] | im_rs[DATA_WIDTH]));
            if (s2_vld_q) begin
                out_re_q <= re_rs[DATA_WIDTH-1:0];
                out_im_q <= im_rs[DATA_WIDTH-1:0];
            end
        end
    end

    assign bus_io.out_valid  = out_vld_q;
    assign bus_io.out_sof    = out_sof_q;
    assign bus_io.out_real   = out_re_q;
    assign bus_io.out_imag   = out_im_q;
    assign bus_io.frame_done = done_q;
    assign bus_io.ovf_flag   = ovf_q;
endmodule
